// File: rtl/video_colorize_if.sv
// Palette write bus for video_colorize.
//   pal_we   : write strobe, sampled on every clk edge (not gated by ce_pix)
//   pal_addr : palette entry 0..15
//   pal_data : {R,G,B}, 8 bits each
// The host drives the master modport; video_colorize receives it as slave.
interface video_colorize_if;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_data;

  modport master (output pal_we, pal_addr, pal_data);
  modport slave  (input  pal_we, pal_addr, pal_data);
endinterface

// File: rtl/video_colorize.sv
// Video output stage: maps 8-bit intensity codes to 24-bit RGB.
// The mapping uses a writable 16-entry palette with 4-bit intensity scaling.
// Optional scanline darkening is applied, and sync/blank strobes are delayed
// to stay aligned with the colour pipeline.
// The block also counts HSync pulses per VSync period.
//
// Ports:
//   clk, reset          video clock, asynchronous active-low reset
//   ce_pix              pixel enable; the pipeline advances only when set
//   video[7:0]          [7:4] palette index, [3:0] intensity
//   HBlank/HSync/VBlank/VSync  generator strobes, active-high
//   scanlines           1 = darken odd lines to 75 %
//   pal                 palette write bus (slave)
//   ce_out              ce_pix delayed by one clk
//   R/G/B               colour output, 3 ce stages behind the input
//   *_o                 strobes aligned with R/G/B
//   frame_lines         HSync count of the last completed frame
//   frame_valid         one-clk pulse when frame_lines updates
module video_colorize (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce_pix,
  input  logic [7:0]      video,
  input  logic            HBlank,
  input  logic            HSync,
  input  logic            VBlank,
  input  logic            VSync,
  input  logic            scanlines,
  video_colorize_if.slave pal,
  output logic            ce_out,
  output logic [7:0]      R,
  output logic [7:0]      G,
  output logic [7:0]      B,
  output logic            HBlank_o,
  output logic            HSync_o,
  output logic            VBlank_o,
  output logic            VSync_o,
  output logic [9:0]      frame_lines,
  output logic            frame_valid
);

  // (c * (k+1)) >> 4. The largest product is 255*16 = 4080, so 12 bits hold it.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] k);
    logic [11:0] p;
    p = {4'd0, c} * ({8'd0, k} + 12'd1);
    return p[11:4];
  endfunction

  function automatic logic [7:0] dim(input logic [7:0] c, input logic en);
    return en ? (c - {2'b00, c[7:2]}) : c;
  endfunction

  // ---------------- palette ----------------
  logic [23:0] palette [16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 16; i++)
        palette[4'(i)] <= {3{8'(i * 32'd17)}};
    end else if (pal.pal_we) begin
      palette[pal.pal_addr] <= pal.pal_data;
    end
  end

  // ---------------- S1 ----------------
  logic [7:0] s1_video;
  logic       s1_hb, s1_hs, s1_vb, s1_vs;
  logic       s1_hs_prev, s1_vs_prev;
  logic       hs_rise, vs_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_video   <= '0;
      s1_hb      <= 1'b0;
      s1_hs      <= 1'b0;
      s1_vb      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_hs_prev <= 1'b0;
      s1_vs_prev <= 1'b0;
    end else if (ce_pix) begin
      s1_video   <= video;
      s1_hb      <= HBlank;
      s1_hs      <= HSync;
      s1_vb      <= VBlank;
      s1_vs      <= VSync;
      s1_hs_prev <= s1_hs;
      s1_vs_prev <= s1_vs;
    end
  end

  assign hs_rise = s1_hs & ~s1_hs_prev;
  assign vs_rise = s1_vs & ~s1_vs_prev;

  // ---------------- line counter ----------------
  logic [9:0]  line_cnt;
  logic [10:0] lc_next;

  // One saturating adder serves both the per-line increment and the
  // "line counts toward the ending frame" case on a simultaneous VSync rise.
  always_comb begin
    lc_next = {1'b0, line_cnt} + {10'd0, hs_rise};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_cnt    <= '0;
      frame_lines <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (ce_pix) begin
        if (vs_rise) begin
          frame_lines <= lc_next[10] ? '1 : lc_next[9:0];
          line_cnt    <= '0;
          frame_valid <= 1'b1;
        end else if (hs_rise) begin
          line_cnt    <= lc_next[10] ? '1 : lc_next[9:0];
        end
      end
    end
  end

  // ---------------- S2 ----------------
  logic [23:0] pal_rd;
  logic [23:0] scaled;
  logic [7:0]  s2_r, s2_g, s2_b;
  logic        s2_hb, s2_hs, s2_vb, s2_vs, s2_par;

  always_comb begin
    pal_rd = palette[s1_video[7:4]];
    scaled = {scale(pal_rd[23:16], s1_video[3:0]),
              scale(pal_rd[15:8],  s1_video[3:0]),
              scale(pal_rd[7:0],   s1_video[3:0])};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_r   <= '0;
      s2_g   <= '0;
      s2_b   <= '0;
      s2_hb  <= 1'b0;
      s2_hs  <= 1'b0;
      s2_vb  <= 1'b0;
      s2_vs  <= 1'b0;
      s2_par <= 1'b0;
    end else if (ce_pix) begin
      {s2_r, s2_g, s2_b} <= scaled;
      s2_hb  <= s1_hb;
      s2_hs  <= s1_hs;
      s2_vb  <= s1_vb;
      s2_vs  <= s1_vs;
      s2_par <= line_cnt[0];
    end
  end

  // ---------------- S3 ----------------
  logic       darken, blank;
  logic [7:0] r3, g3, b3;

  always_comb begin
    darken = scanlines & s2_par;
    blank  = s2_hb | s2_vb;
    r3 = blank ? 8'd0 : dim(s2_r, darken);
    g3 = blank ? 8'd0 : dim(s2_g, darken);
    b3 = blank ? 8'd0 : dim(s2_b, darken);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      R        <= '0;
      G        <= '0;
      B        <= '0;
      HBlank_o <= 1'b0;
      HSync_o  <= 1'b0;
      VBlank_o <= 1'b0;
      VSync_o  <= 1'b0;
    end else if (ce_pix) begin
      R        <= r3;
      G        <= g3;
      B        <= b3;
      HBlank_o <= s2_hb;
      HSync_o  <= s2_hs;
      VBlank_o <= s2_vb;
      VSync_o  <= s2_vs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ce_out <= 1'b0;
    else        ce_out <= ce_pix;
  end

endmodule

// File: tb/tb_video_colorize.sv
// Scoreboard bench for video_colorize. The stimulus process pushes one
// expected pixel per ce and one expected frame_lines per VSync rise. The
// negedge monitor pops and compares whenever ce_out / frame_valid is high.
module tb_video_colorize;

  localparam logic [3:0] HB = 4'b1000, HS = 4'b0100, VB = 4'b0010, VS = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic [7:0]  video = '0;
  logic        HBlank = 1'b0, HSync = 1'b0, VBlank = 1'b0, VSync = 1'b0;
  logic        scanlines = 1'b0;
  logic        ce_out;
  logic [7:0]  R, G, B;
  logic        HBlank_o, HSync_o, VBlank_o, VSync_o;
  logic [9:0]  frame_lines;
  logic        frame_valid;

  video_colorize_if pal_if ();

  video_colorize dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .video(video),
    .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
    .scanlines(scanlines), .pal(pal_if),
    .ce_out(ce_out), .R(R), .G(G), .B(B),
    .HBlank_o(HBlank_o), .HSync_o(HSync_o), .VBlank_o(VBlank_o), .VSync_o(VSync_o),
    .frame_lines(frame_lines), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [23:0] rgb;
    logic [3:0]  st;   // {HBlank, HSync, VBlank, VSync}
  } exp_t;

  exp_t pq[$];
  int   fq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   lines_since = 0;
  bit   prev_hs = 1'b0, prev_vs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int sat1023(input int x);
    return (x > 1023) ? 1023 : x;
  endfunction

  // ---------------- monitor ----------------
  exp_t e_cur;
  exp_t last_e;
  logic last_ce, last_rst;
  logic prev_fv = 1'b0;

  always @(posedge clk) begin
    last_ce  = ce_pix;
    last_rst = reset;
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (last_rst === 1'b1) check("ce_out", 32'(ce_out), 32'(last_ce));
      if (ce_out === 1'b1) begin
        if (pq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pix_queue: output with nothing expected (t=%0t)", $time);
        end else begin
          e_cur  = pq.pop_front();
          last_e = e_cur;
          if (e_cur.chk) begin
            check("rgb", 32'({R, G, B}), 32'(e_cur.rgb));
            check("strobes", 32'({HBlank_o, HSync_o, VBlank_o, VSync_o}), 32'(e_cur.st));
          end
        end
      end else if (last_e.chk) begin
        check("hold_rgb", 32'({R, G, B}), 32'(last_e.rgb));
        check("hold_strobes", 32'({HBlank_o, HSync_o, VBlank_o, VSync_o}), 32'(last_e.st));
      end
      if (frame_valid === 1'b1) begin
        if (fq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL frame_valid: pulse with nothing expected, frame_lines=%0d (t=%0t)",
                   frame_lines, $time);
        end else begin
          check("frame_lines", 32'(frame_lines), 32'(fq.pop_front()));
        end
      end
      if (prev_fv === 1'b1) check("fv_width", 32'(frame_valid), 32'(0));
      prev_fv = frame_valid;
    end
  end

  // ---------------- stimulus ----------------
  // Entry/exit point of every task below: 1 time unit after a rising edge.
  task automatic step(input logic [7:0] v, input logic [3:0] st, input bit chk,
                      input logic [23:0] rgb, input int gap = 0,
                      input bit we = 1'b0, input logic [3:0] wa = '0,
                      input logic [23:0] wd = '0);
    bit hs_r;
    video = v;
    {HBlank, HSync, VBlank, VSync} = st;
    ce_pix = 1'b1;
    pal_if.pal_we   = we;
    pal_if.pal_addr = wa;
    pal_if.pal_data = wd;
    hs_r = st[2] && !prev_hs;
    if (st[0] && !prev_vs) begin
      fq.push_back(sat1023(lines_since + (hs_r ? 1 : 0)));
      lines_since = 0;
    end else if (hs_r) begin
      lines_since = sat1023(lines_since + 1);
    end
    prev_hs = st[2];
    prev_vs = st[0];
    pq.push_back('{chk, rgb, st});
    @(posedge clk); #1;
    ce_pix = 1'b0;
    pal_if.pal_we = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
    pal_if.pal_we   = 1'b1;
    pal_if.pal_addr = a;
    pal_if.pal_data = d;
    @(posedge clk); #1;
    pal_if.pal_we = 1'b0;
  endtask

  task automatic line4(input int gap);
    step(8'h00, HS, 1'b1, 24'h0, gap);
    repeat (3) step(8'h00, 4'b0, 1'b1, 24'h0, gap);
  endtask

  task automatic flush2();
    repeat (2) step(8'h00, 4'b0, 1'b0, 24'h0, 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_rgb", 32'({R, G, B}), 32'(0));
    check("rst_strobes", 32'({HBlank_o, HSync_o, VBlank_o, VSync_o}), 32'(0));
    check("rst_ce_out", 32'(ce_out), 32'(0));
    check("rst_frame_lines", 32'(frame_lines), 32'(0));
    check("rst_frame_valid", 32'(frame_valid), 32'(0));
    ce_pix = 1'b0;
    {HBlank, HSync, VBlank, VSync} = 4'b0;
    pal_if.pal_we = 1'b0;
    pq.delete();
    fq.delete();
    lines_since = 0;
    prev_hs = 1'b0;
    prev_vs = 1'b0;
    prev_fv = 1'b0;
    last_e = '{1'b1, 24'h0, 4'b0};
    // The first two ce after release shift out reset-state zeros.
    repeat (2) pq.push_back('{1'b1, 24'h0, 4'b0});
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    pal_if.pal_we   = 1'b0;
    pal_if.pal_addr = '0;
    pal_if.pal_data = '0;
    do_reset();

    // Default grey ramp, toggling ce.
    repeat (4) step(8'hFF, 4'b0, 1'b1, 24'hFFFFFF, 1);
    step(8'h83, 4'b0, 1'b1, 24'h222222, 1);
    step(8'h00, 4'b0, 1'b1, 24'h000000, 2);

    // Scaling through a written entry (written while ce_pix=0).
    pal_write(4'd3, 24'h8040FF);
    step(8'h37, 4'b0, 1'b1, 24'h40207F, 1);
    step(8'h30, 4'b0, 1'b1, 24'h08040F, 2);
    step(8'h3A, 4'b0, 1'b1, 24'h582CAF, 1);
    step(8'h3F, 4'b0, 1'b1, 24'h8040FF, 0);

    // Write colliding with the S2 read of the same entry returns old data.
    step(8'h5F, 4'b0, 1'b1, 24'h555555, 0);
    step(8'h5F, 4'b0, 1'b1, 24'h112233, 0, 1'b1, 4'd5, 24'h112233);
    step(8'h5F, 4'b0, 1'b1, 24'h112233, 1);

    // Blank forcing and strobe alignment.
    repeat (2) step(8'hFF, 4'b0, 1'b1, 24'hFFFFFF, 1);
    step(8'hFF, HB | HS, 1'b1, 24'h0, 1);
    repeat (2) step(8'hFF, HB, 1'b1, 24'h0, 1);
    repeat (2) step(8'hFF, 4'b0, 1'b1, 24'hFFFFFF, 1);
    step(8'hFF, VB, 1'b1, 24'h0, 1);
    step(8'hFF, 4'b0, 1'b1, 24'hFFFFFF, 1);

    // Scanlines: VSync (with HSync) starts line 0, which is even.
    flush2();
    scanlines = 1'b1;
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) begin
        step(8'hFF, (p == 0) ? (HS | ((l == 0) ? VS : 4'b0)) : 4'b0,
             (p >= 1), (l % 2 == 1) ? 24'hC0C0C0 : 24'hFFFFFF, 0);
      end
    end
    flush2();
    scanlines = 1'b0;

    // Line counting: 262, 262 + simultaneous rise = 263, saturation.
    step(8'h00, VS, 1'b1, 24'h0, 0);
    repeat (262) line4(0);
    step(8'h00, VS, 1'b1, 24'h0, 0);
    repeat (262) line4(0);
    step(8'h00, HS | VS, 1'b1, 24'h0, 0);
    repeat (3) step(8'h00, 4'b0, 1'b1, 24'h0, 0);
    repeat (1030) line4(0);
    step(8'h00, VS, 1'b1, 24'h0, 0);

    // Mid-frame reset discards the partial count.
    repeat (5) line4(0);
    do_reset();
    repeat (7) line4(0);
    step(8'h00, VS, 1'b1, 24'h0, 0);
    repeat (3) line4(2);
    step(8'h00, VS, 1'b1, 24'h0, 2);
    repeat (4) step(8'h00, 4'b0, 1'b0, 24'h0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("fv_pending", 32'(fq.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
